// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader and the
// instruction memory itself.
//   ldr_state_t : loader FSM states
//   ldr_err_t   : sticky status codes reported on the err port
//   wr_req_t    : one payload byte headed for the memory write port
//   MEM_BYTES_DEF : default instruction memory size in bytes
package imem_pkg;

  localparam int unsigned MEM_BYTES_DEF = 256;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_HDR_HI,
    LDR_HDR_LO,
    LDR_PAYLOAD,
    LDR_CHECK,
    LDR_FIN
  } ldr_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2
  } ldr_err_t;

  typedef struct packed {
    logic [15:0] idx;   // payload byte index within the frame
    logic [7:0]  data;
  } wr_req_t;

  // Byte count of an N-word frame, kept at 18 bits so 4*N never truncates.
  function automatic logic [17:0] frame_bytes(input logic [15:0] n);
    return {n, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Stream-in / memory-write-out bus of the boot loader.
//   in_valid, in_data, in_ready : byte stream handshake (host -> loader)
//   mem_we, mem_addr, mem_wdata : byte write port (loader -> instruction memory)
// slave  : the loader side (consumes the stream, drives the memory port)
// master : the host/memory side
interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_wr_stage.sv
// One-deep registered write-port stage. A payload accept in cycle t
// becomes a memory write in cycle t+1. Address and data only load on an
// accept, so they hold their last values while we is low.
//   clk, rst_n : clock, async active-low reset
//   acc        : payload byte accepted this cycle
//   req        : byte index and data of the accepted byte
//   we, addr, wdata : instruction memory byte write port
module imem_wr_stage
  import imem_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc,
  input  wr_req_t           req,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata
);

  localparam int STAGES = 1;

  logic [STAGES:0]   vld_pipe;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;

  assign vld_pipe[0] = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      addr_q             <= '0;
      wdata_q            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (acc) begin
        // Wraps modulo 2^ADDR_W by construction.
        addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(req.idx);
        wdata_q <= req.data;
      end
    end
  end

  assign we    = vld_pipe[STAGES];
  assign addr  = addr_q;
  assign wdata = wdata_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Parses a framed byte stream
// (CNT_HI, CNT_LO, 4N payload bytes, XOR checksum), writes the payload to
// consecutive byte addresses starting at BASE_ADDR and keeps the CPU in
// reset until a frame completes with a good checksum.
//   clk, rst_n   : clock, async active-low reset
//   start        : pulse that opens a frame, honoured only in IDLE
//   bus          : stream handshake in, memory byte write port out
//   busy         : frame in progress
//   done         : one-cycle pulse at frame end (success or error)
//   err          : sticky status, cleared by the next accepted start
//   cpu_hold     : CPU reset request
//   words_loaded : complete 4-byte words written in the current/last frame
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        cpu_hold,
  output logic [15:0] words_loaded
);

  if (MEM_BYTES < 4 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem
    $error("imem_loader: MEM_BYTES must be a power of two and at least 4");
  end

  // Bytes available from BASE_ADDR to the top of memory.
  localparam int unsigned ROOM = MEM_BYTES - BASE_ADDR;

  ldr_state_t  state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] words_q, words_d;
  logic [7:0]  x_q, x_d;
  ldr_err_t    err_q, err_d;
  logic        hold_q, hold_d;

  logic        rdy, fire, wr_acc, pay_last;
  logic [17:0] len_hdr;

  assign rdy    = state_q inside {LDR_HDR_HI, LDR_HDR_LO, LDR_PAYLOAD, LDR_CHECK};
  assign fire   = bus.in_valid & rdy;
  assign wr_acc = fire && (state_q == LDR_PAYLOAD);

  // 4N formed from the CNT_LO byte on the bus, before it lands in n_q.
  assign len_hdr  = frame_bytes({n_q[15:8], bus.in_data});
  assign pay_last = ({2'b00, idx_q} + 18'd1) == frame_bytes(n_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LDR_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      words_q <= '0;
      x_q     <= '0;
      err_q   <= ERR_NONE;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      x_q     <= x_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    words_d = words_q;
    x_d     = x_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      LDR_IDLE: begin
        if (start) begin
          state_d = LDR_HDR_HI;
          err_d   = ERR_NONE;
          words_d = '0;
          x_d     = '0;
          idx_d   = '0;
          hold_d  = 1'b1;
        end
      end
      LDR_HDR_HI: begin
        if (fire) begin
          n_d     = {bus.in_data, n_q[7:0]};
          state_d = LDR_HDR_LO;
        end
      end
      LDR_HDR_LO: begin
        if (fire) begin
          n_d   = {n_q[15:8], bus.in_data};
          idx_d = '0;
          if ({14'd0, len_hdr} > ROOM) begin
            err_d   = ERR_LEN;
            state_d = LDR_FIN;
          end else if (len_hdr == '0) begin
            state_d = LDR_CHECK;
          end else begin
            state_d = LDR_PAYLOAD;
          end
        end
      end
      LDR_PAYLOAD: begin
        if (fire) begin
          x_d   = x_q ^ bus.in_data;
          idx_d = idx_q + 16'd1;
          if (idx_q[1:0] == 2'd3) words_d = words_q + 16'd1;
          if (pay_last) state_d = LDR_CHECK;
        end
      end
      LDR_CHECK: begin
        if (fire) begin
          if (bus.in_data != x_q) err_d = ERR_CSUM;
          state_d = LDR_FIN;
        end
      end
      LDR_FIN: begin
        // err_q already holds the final status of this frame.
        hold_d  = (err_q != ERR_NONE);
        state_d = LDR_IDLE;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  imem_wr_stage #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .acc   (wr_acc),
    .req   ('{idx: idx_q, data: bus.in_data}),
    .we    (bus.mem_we),
    .addr  (bus.mem_addr),
    .wdata (bus.mem_wdata)
  );

  assign bus.in_ready  = rdy;
  assign busy          = (state_q != LDR_IDLE);
  assign done          = (state_q == LDR_FIN);
  assign err           = err_q;
  assign cpu_hold      = hold_q;
  assign words_loaded  = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed, big-endian instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes each payload byte to consecutive memory addresses, so stream order equals big-endian word layout.
- Holds the CPU in reset until a load completes with a good checksum.
- Sits between the host/UART byte source and the instruction memory write port.

Parameters:
- MEM_BYTES, 256, instruction memory size in bytes; must be a power of two and at least 4.
- ADDR_W, 32, memory address width; matches the fetch address width.
- BASE_ADDR, 0, byte address of the first payload byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load frame; ignored while busy.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both high.
- mem_we  out  1  byte write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end, on success or error.
- err  out  2  sticky status: 0 none, 1 length overflow, 2 checksum mismatch.
- cpu_hold  out  1  keeps the CPU in reset.
- words_loaded  out  16  count of complete 4-byte words written in the current or last frame.

Behaviour:
- Frame format: CNT_HI, CNT_LO (big-endian word count N), then 4N payload bytes, then one checksum byte equal to the XOR of all payload bytes.
- Reset: all outputs 0 except cpu_hold=1. State IDLE, counters cleared, running XOR 0x00.
- FSM states: IDLE, HDR_HI, HDR_LO, PAYLOAD, CHECK, FIN.
- IDLE: in_ready=0. On start, go to HDR_HI, set busy=1, clear err, words_loaded and XOR, and set cpu_hold=1.
- HDR_HI / HDR_LO: in_ready=1; each accepted byte latches into N.
- After HDR_LO is accepted:
  - If 4N > MEM_BYTES - BASE_ADDR: err=1, go to FIN. No writes occur.
  - Else if N=0: go to CHECK.
  - Else: go to PAYLOAD with byte index 0.
- PAYLOAD: in_ready=1. For each byte accepted in cycle t:
  - In cycle t+1: mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=byte. Write latency is exactly one cycle.
  - XOR and index update in the same edge. words_loaded increments when index[1:0] wraps 3→0.
  - After byte 4N-1 is accepted, go to CHECK.
- Back-to-back accepts: one write per cycle, no bubbles. When in_valid=0, in_ready stays high and no write is issued.
- CHECK: in_ready=1. On accept, compare the byte with the running XOR; on mismatch set err=2. Go to FIN.
- FIN: in_ready=0. done=1 for exactly this cycle, busy drops to 0 the next cycle, and return to IDLE. cpu_hold=0 only if err=0; otherwise it stays 1.
- mem_we is never asserted outside the cycle following a PAYLOAD accept. mem_addr and mem_wdata hold their last values when mem_we=0.
- start during HDR_HI through FIN has no effect.
- start coincident with FIN is ignored; a new start must arrive in IDLE.
- Index arithmetic: 16-bit byte counter compared against 4N in 18 bits, so no truncation. Address = BASE_ADDR + zero-extended index, modulo 2^ADDR_W.
- Async reset mid-frame: immediate return to reset values. Any partially written memory contents are left as they are, and cpu_hold is reasserted.
- err persists until the next accepted start.

Decomposition:
- Shared package imem_pkg holds:
  - state enum LDR_IDLE..LDR_FIN;
  - error codes ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2;
  - default MEM_BYTES=256, shared with the instruction memory.
- Natural sub-module: imem_wr_stage, a one-deep registered write-port stage that generates mem_we/mem_addr/mem_wdata from the accept strobe.
- The FSM and counters live in the top module.

Test Plan:
- Nominal load: start, then bytes 00 04, 00 11 10 AA, 00 11 15 AA, 00 22 10 BB, 00 33 10 CC, checksum 63.
  - 16 writes to addr 0..15 with matching data, each one cycle after its accept.
  - done pulse, err=0, words_loaded=4, cpu_hold falls to 0.
- Bad checksum: same frame with checksum 64 → all 16 writes occur, err=2, done pulses, cpu_hold stays 1.
- Length overflow (MEM_BYTES=256): header 00 41 (N=65) → err=1 and done right after CNT_LO, zero writes, in_ready=0 afterwards.
- Zero-length frame: header 00 00, checksum 00 → no writes, err=0, words_loaded=0, cpu_hold=0.
- Backpressure and gaps: random in_valid gaps during payload → write count and addresses unchanged.
  - Also pulse start mid-payload → ignored, frame completes normally.
- Reset mid-frame: assert rst_n=0 after 6 payload bytes → busy=0, mem_we=0, cpu_hold=1, err=0 immediately.
  - A following full nominal frame then succeeds.
